// File: rtl/int_operand_collector_pkg.sv
// Shared integer-core types: ALU opcodes, default widths and the operand
// collector FSM state encoding.
package cudacore_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = $clog2(NREGS_DEF);

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    SHFTL = 3'd2,
    SHFTR = 3'd3,
    AND   = 3'd4,
    OR    = 3'd5,
    XOR   = 3'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RD_A  = 3'd2,
    ST_RD_B  = 3'd3,
    ST_OUT   = 3'd4
  } coll_state_t;

endpackage

// File: rtl/int_operand_collector_scoreboard.sv
// Per-register busy vector with issue-set / writeback-clear and a
// two-source RAW hazard query against the registered vector.
module int_scoreboard #(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_set,
  input  logic [$clog2(NREGS)-1:0] i_set_rd,
  input  logic                     i_clr,
  input  logic [$clog2(NREGS)-1:0] i_clr_rd,
  input  logic [$clog2(NREGS)-1:0] i_rs1,
  input  logic [$clog2(NREGS)-1:0] i_rs2,
  input  logic                     i_use_imm,
  output logic                     o_hazard,
  output logic [NREGS-1:0]         o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clear is applied before set so an issue and a writeback to the same
  // register in one cycle leaves it busy; r0 can never be marked busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_rd] = 1'b0;
    if (i_set) w_busy_nxt[i_set_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_hazard = r_busy[i_rs1] | (~i_use_imm & r_busy[i_rs2]);
  assign o_busy   = r_busy;

endmodule

// File: rtl/int_operand_collector.sv
// Integer operand collector: RAW scoreboard check, operand fetch from a
// single-port synchronous register file, and ALU hand-off.
module int_operand_collector
  import cudacore_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic                     in_use_imm,
  output logic                     rf_rd_en,
  output logic [$clog2(NREGS)-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]        rf_rd_data,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_a,
  output logic [DATA_W-1:0]        out_b,
  output logic [2:0]               out_op,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output coll_state_t              o_dbg_state,
  output logic [NREGS-1:0]         o_dbg_busy
);

  localparam int REG_W = $clog2(NREGS);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready, and ready never depends
  // on valid, and the payload is held stable while valid waits for ready.

  coll_state_t       r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [REG_W-1:0]  r_rd, r_rs1, r_rs2, r_rd_addr_q;
  logic [DATA_W-1:0] r_imm, r_a, r_b;
  logic              r_use_imm;

  logic              w_hazard;
  logic              w_rd_en;
  logic [REG_W-1:0]  w_rd_addr;
  logic              w_accept;
  logic              w_issue;

  assign w_accept = (r_state == ST_IDLE) & in_valid;
  assign w_issue  = (r_state == ST_OUT) & out_ready;

  int_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_issue),
    .i_set_rd  (r_rd),
    .i_clr     (wb_valid),
    .i_clr_rd  (wb_rd),
    .i_rs1     (r_rs1),
    .i_rs2     (r_rs2),
    .i_use_imm (r_use_imm),
    .o_hazard  (w_hazard),
    .o_busy    (o_dbg_busy)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_rd_addr_q;
    unique case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!w_hazard) begin
          w_rd_en     = 1'b1;
          w_rd_addr   = r_rs1;
          w_state_nxt = ST_RD_A;
        end
      end
      ST_RD_A: begin
        if (r_use_imm) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_rd_en     = 1'b1;
          w_rd_addr   = r_rs2;
          w_state_nxt = ST_RD_B;
        end
      end
      ST_RD_B:  w_state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd_addr_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_en) r_rd_addr_q <= w_rd_addr;
      if (w_accept) begin
        r_op      <= in_op;
        r_rd      <= in_rd;
        r_rs1     <= in_rs1;
        r_rs2     <= in_rs2;
        r_imm     <= in_imm;
        r_use_imm <= in_use_imm;
      end
      // Register file data arrives the cycle after the strobe; r0 reads as zero.
      if (r_state == ST_RD_A) begin
        r_a <= (r_rs1 == '0) ? '0 : rf_rd_data;
        if (r_use_imm) r_b <= r_imm;
      end
      if (r_state == ST_RD_B) r_b <= (r_rs2 == '0) ? '0 : rf_rd_data;
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_OUT);
  assign rf_rd_en    = w_rd_en;
  assign rf_rd_addr  = w_rd_addr;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign out_op      = r_op;
  assign out_rd      = r_rd;
  assign o_dbg_state = r_state;

endmodule

// File: doc/int_operand_collector.md
Name: int_operand_collector

Overview:
Issue-side stage directly upstream of the integer ALU in the CUDA core. It accepts one decoded integer instruction at a time and checks a per-register scoreboard for RAW hazards. It then reads the source operands from a single-read-port synchronous register file and presents {A, B, op, rd} to the ALU with a valid/ready handshake. It marks rd busy on issue and clears it on writeback.

Parameters:
NREGS, 32, number of architectural integer registers; r0 is hardwired to zero.
REG_W, $clog2(NREGS), register index width (derived, not overridden).
DATA_W, 32, operand width; must match the ALU.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  decoded instruction valid.
in_ready  out  1  collector can accept; high only in IDLE.
in_op  in  3  ALU opcode (alu_op_t).
in_rd  in  REG_W  destination register.
in_rs1  in  REG_W  source 1.
in_rs2  in  REG_W  source 2; ignored when in_use_imm=1.
in_imm  in  DATA_W  immediate used as B.
in_use_imm  in  1  B comes from in_imm, not rs2.
rf_rd_en  out  1  register-file read strobe.
rf_rd_addr  out  REG_W  read address.
rf_rd_data  in  DATA_W  read data, valid exactly 1 cycle after rf_rd_en.
wb_valid  in  1  writeback completed this cycle.
wb_rd  in  REG_W  register written back; its busy bit is cleared.
out_valid  out  1  operands valid to ALU.
out_ready  in  1  ALU/downstream accepts.
out_a  out  DATA_W  operand A.
out_b  out  DATA_W  operand B.
out_op  out  3  opcode forwarded unchanged.
out_rd  out  REG_W  destination forwarded unchanged.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, scoreboard all 0, out_valid=0, out_a/out_b=0, out_op=0, out_rd=0, rf_rd_en=0, rf_rd_addr=0.
  - Reset asserted mid-operation discards the in-flight instruction; no busy bit survives.
- FSM states: IDLE, CHECK, RD_A, RD_B, OUT.
- IDLE:
  - in_ready=1 (combinational from state only, never from in_valid).
  - in_valid=1 latches op, rd, rs1, rs2, imm, use_imm and moves to CHECK.
- CHECK:
  - hazard = sb[rs1] | (!use_imm & sb[rs2]), using the registered scoreboard; there is no same-cycle writeback bypass.
  - If hazard=1, stay in CHECK.
  - Otherwise assert rf_rd_en with rf_rd_addr=rs1 and move to RD_A.
- RD_A:
  - Capture A = (rs1==0) ? 0 : rf_rd_data.
  - If use_imm=1: B=imm, go to OUT.
  - Otherwise assert rf_rd_en with rf_rd_addr=rs2 and go to RD_B.
- RD_B: capture B = (rs2==0) ? 0 : rf_rd_data, go to OUT.
- OUT:
  - out_valid=1; out_* are held stable while out_ready=0.
  - On out_valid & out_ready: set sb[rd] (unless rd=0), go to IDLE.
- Latency from the accept cycle t: out_valid asserts at t+4 for register-register and t+3 for immediate, with no stalls. Throughput is at most 1 instruction per 5 or 4 cycles.
- rf_rd_en is high only in the cycles listed above; rf_rd_addr holds its last value otherwise.
- Scoreboard:
  - NREGS-bit vector; bit 0 always 0.
  - wb_valid clears sb[wb_rd].
  - Clearing a bit that is not set is a no-op.
  - Simultaneous set (issue) and clear (writeback) of the same register: set wins.
- Opcode 3'b111 is not trapped; it is forwarded as-is and the ALU defines the result.
- B is passed at full width; shift-amount truncation belongs to the ALU.

Decomposition:
- Package cudacore_pkg (cudacore.svh) holds:
  - typedef enum logic [2:0] alu_op_t {ADD=0, SUB=1, SHFTL=2, SHFTR=3, AND=4, OR=5, XOR=6}.
  - Register index width, DATA_W default, and the collector FSM state enum.
- One natural sub-module: int_scoreboard, holding the busy vector, set/clear ports and the two-source hazard query.

Test Plan:
- Reset: assert rst 2 cycles mid-RD_A -> next cycle out_valid=0, in_ready=1, rf_rd_en=0, all busy bits 0.
- Reg-reg ADD, rd=3, rs1=1, rs2=2, RF r1=5, r2=7, accept at t:
  - rf_rd_addr=1 at t+1 and 2 at t+2.
  - out_valid at t+4 with out_a=5, out_b=7, out_op=0, out_rd=3.
- Immediate SHFTL, rd=4, rs1=1, imm=3 -> one read only (addr 1); out_valid at t+3 with out_b=3.
- RAW hazard:
  - Issue ADD writing r3, then SUB reading r3 -> SUB stays in CHECK.
  - wb_valid=1, wb_rd=3 at cycle k -> read of r3 issues at k+1.
- Backpressure: out_ready=0 for 5 cycles -> out_* constant, in_ready=0; out_ready=1 -> IDLE next cycle.
- r0 handling: rs1=0 with RF returning 0xFFFFFFFF -> out_a=0. rd=0 issued -> sb[0] stays 0, a following read of r0 does not stall.
